load_store_unit: RTL and testbench
==================================

# load_store_unit

Multicycle data-memory access unit that consumes the memory controls produced by the control unit (`memWrite`, `loadCtrl`, `storeCtrl`) together with the ALU-computed effective address. It drives a simple request/ready data-memory bus, aligns store data and byte enables, and sign- or zero-extends load data. It stalls the core until the access completes. It sits in the execute/memory stage, between the ALU and the result-select mux.

## Interface
- `ADDR_WIDTH`, 32, width of the effective address and of `busAddr`.
- `DATA_WIDTH`, 32, data width; only 32 is supported.

- `clk`  in  1  single clock, rising edge.
- `rstN`  in  1  asynchronous, active-low reset.
- `memValid`  in  1  the current instruction is a load or store; held until `stall` is low.
- `memWrite`  in  1  1 = store, 0 = load.
- `loadCtrl`  in  3  000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; other codes are illegal.
- `storeCtrl`  in  2  00 SB, 01 SH, 10 SW; 11 is illegal.
- `ALUResult`  in  32  effective byte address.
- `writeData`  in  32  store source (rs2).
- `stall`  out  1  hold PC and pipeline registers.
- `readData`  out  32  extended load result; valid when `readValid` = 1.
- `readValid`  out  1  one-cycle pulse on load completion.
- `fault`  out  1  one-cycle pulse on a misaligned access or an illegal ctrl code.
- `busReq`  out  1  bus request.
- `busWe`  out  1  bus write enable.
- `busAddr`  out  32  word-aligned address: `{addr[31:2],2'b00}`.
- `busBE`  out  4  byte-lane enables.
- `busWData`  out  32  lane-replicated store data.
- `busReady`  in  1  access accepted; for a load, `busRData` is valid in the same cycle.
- `busRData`  in  32  read word.

## Operation
- **FSM states:** IDLE, REQ, DONE. Reset state is IDLE.
- **IDLE:**
  - `memValid` = 0: stay in IDLE.
  - `memValid` = 1 and access legal: capture address, BE, write data and ctrl; go to REQ.
  - `memValid` = 1 and access misaligned or illegal: capture a fault flag; go to DONE with no bus activity.
- **REQ:** `busReq` = 1, with address, BE, data and we held stable from the capture registers. On `busReady` = 1 at a rising edge:
  - load: register the extended `busRData`;
  - go to DONE.
- **DONE:** on the next edge, go to IDLE unconditionally. `memValid` is ignored in DONE because the same instruction is still presented.
- **Misalignment rules:**
  - LH/LHU/SH fault when `addr[0]` ≠ 0.
  - LW/SW fault when `addr[1:0]` ≠ 0.
  - Byte accesses never fault.
- **Byte enables:**
  - byte: `4'b0001 << addr[1:0]`;
  - half: `4'b0011 << addr[1:0]`;
  - word: `4'b1111`.
  - Loads use the same BE rules.
- **Store data:** SB replicates `wd[7:0]` ×4; SH replicates `wd[15:0]` ×2; SW passes `wd` through.
- **Load data:** shift `busRData` right by `8*addr[1:0]`, then:
  - LB/LH: sign-extend bit 7/15;
  - LBU/LHU: zero-extend;
  - LW: pass through.
- `busWData` = 0 for loads.

## Timing
- **Reset values:**
  - all registered outputs are 0: `busReq`, `busWe`, `busAddr`, `busBE`, `busWData`, `readData`, `readValid`, `fault`;
  - `stall` is forced 0 while `rstN` = 0.
- **Asserting `rstN` low mid-access** (in REQ or DONE):
  - state goes to IDLE immediately;
  - `busReq` drops asynchronously;
  - no `readValid` or `fault` is produced for the aborted access.
- **`stall` (combinational):** `(state==IDLE && memValid) || state==REQ`. It is low in DONE.
- **Latency:**
  - Zero-wait bus: IDLE at cycle 0, REQ with `busReady` at cycle 1, DONE at cycle 2. Total 3 cycles; `stall` is high for cycles 0–1.
  - N wait cycles add N cycles in REQ.
- **Fault path:** IDLE at cycle 0, DONE at cycle 1 with `fault` = 1; `stall` is high for 1 cycle.
- **`readValid` / `fault`:** high only in DONE, never simultaneously. `readValid` is 0 for stores.
- **Bus rule:** `busReq` never drops before `busReady`. Bus fields do not change while `busReq` = 1.

## Structure
- **Package `lsu_pkg`:**
  - `loadCtrl` encodings: `LD_B`, `LD_H`, `LD_W`, `LD_BU`, `LD_HU`;
  - `storeCtrl` encodings: `ST_B`, `ST_H`, `ST_W`;
  - state enum `lsu_state_t`.
- **Sub-module `load_extend`:** combinational; inputs word, offset and `loadCtrl`; output is the extended 32-bit result. It is reused by any future cache path.
- Store alignment and BE generation stay inline.

## Test plan
- **SW** with `addr` = 0x100, `wd` = 0xDEADBEEF, `busReady` tied 1: `busReq` in cycle 1 with `busAddr` 0x100, BE 1111, `busWData` 0xDEADBEEF, we = 1; `stall` high for 2 cycles; `readValid` stays 0.
- **LB** at 0x203, `busRData` 0x80FF_0000: `busBE` = 1000; `readData` = 0xFFFFFF80 in DONE; LBU at the same address gives 0x00000080.
- **LH** at 0x102, `busRData` 0x8001_1234, `busReady` delayed 3 cycles: `readData` = 0xFFFF8001; `stall` high for 5 cycles; bus fields stable throughout REQ.
- **SH** at 0x101: `fault` pulses in cycle 1; `busReq` never asserts; `stall` high for 1 cycle. `loadCtrl` = 011 behaves the same way.
- **Reset** asserted while in REQ with `busReady` = 0: `busReq`, `stall` and `readValid` go 0 at once. After release with `memValid` = 0, the unit stays in IDLE.
- **Back-to-back** SB at 0x0 then LW at 0x4: the second request issues the cycle after DONE. SB gives `busWData` = `{4{wd[7:0]}}` with BE 0001.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared encodings, state type and access-decode helpers for the load/store unit.
package lsu_pkg;

   localparam int unsigned WORD_W    = 32;
   localparam int unsigned BE_W      = 4;
   localparam int unsigned LD_CTRL_W = 3;
   localparam int unsigned ST_CTRL_W = 2;
   localparam int unsigned OFF_W     = 2;

   localparam logic [LD_CTRL_W-1:0] LD_B  = 3'b000;
   localparam logic [LD_CTRL_W-1:0] LD_H  = 3'b001;
   localparam logic [LD_CTRL_W-1:0] LD_W  = 3'b010;
   localparam logic [LD_CTRL_W-1:0] LD_BU = 3'b100;
   localparam logic [LD_CTRL_W-1:0] LD_HU = 3'b101;

   localparam logic [ST_CTRL_W-1:0] ST_B = 2'b00;
   localparam logic [ST_CTRL_W-1:0] ST_H = 2'b01;
   localparam logic [ST_CTRL_W-1:0] ST_W = 2'b10;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_DONE = 2'd2
   } lsu_state_t;

   typedef enum logic [1:0] {
      SZ_BYTE = 2'd0,
      SZ_HALF = 2'd1,
      SZ_WORD = 2'd2,
      SZ_BAD  = 2'd3
   } acc_size_t;

   // Request fields held on the bus while a request is outstanding
   typedef struct packed {
      logic              we;
      logic [BE_W-1:0]   be;
      logic [WORD_W-1:0] wdata;
   } bus_payload_t;

   // Access size from the ctrl code; SZ_BAD flags an illegal encoding
   function automatic acc_size_t access_size(input logic                 we,
                                             input logic [LD_CTRL_W-1:0] ld,
                                             input logic [ST_CTRL_W-1:0] st);
      acc_size_t sz;
      sz = SZ_BAD;
      if (we) begin
         case (st)
            ST_B:    sz = SZ_BYTE;
            ST_H:    sz = SZ_HALF;
            ST_W:    sz = SZ_WORD;
            default: sz = SZ_BAD;
         endcase
      end else begin
         case (ld)
            LD_B, LD_BU: sz = SZ_BYTE;
            LD_H, LD_HU: sz = SZ_HALF;
            LD_W:        sz = SZ_WORD;
            default:     sz = SZ_BAD;
         endcase
      end
      return sz;
   endfunction

   function automatic logic misaligned(input acc_size_t sz, input logic [OFF_W-1:0] off);
      logic bad;
      bad = 1'b0;
      case (sz)
         SZ_HALF: bad = off[0];
         SZ_WORD: bad = (off != 2'b00);
         default: bad = 1'b0;
      endcase
      return bad;
   endfunction

   function automatic logic [BE_W-1:0] be_for(input acc_size_t sz, input logic [OFF_W-1:0] off);
      logic [BE_W-1:0] be;
      be = '0;
      case (sz)
         SZ_BYTE: be = BE_W'(4'b0001 << off);
         SZ_HALF: be = BE_W'(4'b0011 << off);
         SZ_WORD: be = 4'b1111;
         default: be = '0;
      endcase
      return be;
   endfunction

   // Replicate the store source across every lane the access could hit
   function automatic logic [WORD_W-1:0] store_lanes(input acc_size_t sz,
                                                     input logic [WORD_W-1:0] wd);
      logic [WORD_W-1:0] lanes;
      lanes = '0;
      case (sz)
         SZ_BYTE: lanes = {4{wd[7:0]}};
         SZ_HALF: lanes = {2{wd[15:0]}};
         SZ_WORD: lanes = wd;
         default: lanes = '0;
      endcase
      return lanes;
   endfunction

endpackage

// File: rtl/load_extend.sv
// Aligns a read word to the addressed lane and sign/zero-extends per load type.
module load_extend (
   input  logic [31:0] word,
   input  logic [1:0]  offset,
   input  logic [2:0]  load_ctrl,
   output logic [31:0] result
);
   import lsu_pkg::*;

   logic [WORD_W-1:0] shifted;

   always_comb begin
      result  = '0;
      shifted = word >> {offset, 3'b000};
      case (load_ctrl)
         LD_B:    result = {{24{shifted[7]}}, shifted[7:0]};
         LD_H:    result = {{16{shifted[15]}}, shifted[15:0]};
         LD_W:    result = shifted;
         LD_BU:   result = {24'd0, shifted[7:0]};
         LD_HU:   result = {16'd0, shifted[15:0]};
         default: result = '0;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// Multicycle load/store unit: IDLE -> REQ (bus handshake) -> DONE, stalling the core
// until the access or its fault completes.
module load_store_unit #(
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rstN,
   input  logic                  memValid,
   input  logic                  memWrite,
   input  logic [2:0]            loadCtrl,
   input  logic [1:0]            storeCtrl,
   input  logic [ADDR_WIDTH-1:0] ALUResult,
   input  logic [DATA_WIDTH-1:0] writeData,
   output logic                  stall,
   output logic [DATA_WIDTH-1:0] readData,
   output logic                  readValid,
   output logic                  fault,
   output logic                  busReq,
   output logic                  busWe,
   output logic [ADDR_WIDTH-1:0] busAddr,
   output logic [3:0]            busBE,
   output logic [DATA_WIDTH-1:0] busWData,
   input  logic                  busReady,
   input  logic [DATA_WIDTH-1:0] busRData
);
   import lsu_pkg::*;

   lsu_state_t             state_q, state_d;
   logic                   req_q, req_d;
   logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
   bus_payload_t           pay_q, pay_d;
   logic [LD_CTRL_W-1:0]   ld_ctrl_q, ld_ctrl_d;
   logic [OFF_W-1:0]       off_q, off_d;
   logic [DATA_WIDTH-1:0]  rdata_q, rdata_d;
   logic                   rvalid_q, rvalid_d;
   logic                   fault_q, fault_d;

   acc_size_t              size;
   logic                   bad;
   logic [WORD_W-1:0]      ext_word;

   assign size = access_size(memWrite, loadCtrl, storeCtrl);
   assign bad  = (size == SZ_BAD) || misaligned(size, ALUResult[1:0]);

   load_extend u_load_extend (
      .word      (busRData),
      .offset    (off_q),
      .load_ctrl (ld_ctrl_q),
      .result    (ext_word)
   );

   // Next-state and next-output logic
   always_comb begin
      state_d   = state_q;
      req_d     = req_q;
      addr_d    = addr_q;
      pay_d     = pay_q;
      ld_ctrl_d = ld_ctrl_q;
      off_d     = off_q;
      rdata_d   = rdata_q;
      rvalid_d  = 1'b0;
      fault_d   = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (memValid) begin
               if (bad) begin
                  fault_d = 1'b1;
                  state_d = S_DONE;
               end else begin
                  req_d       = 1'b1;
                  addr_d      = {ALUResult[ADDR_WIDTH-1:2], 2'b00};
                  pay_d.we    = memWrite;
                  pay_d.be    = be_for(size, ALUResult[1:0]);
                  pay_d.wdata = memWrite ? store_lanes(size, writeData) : '0;
                  ld_ctrl_d   = loadCtrl;
                  off_d       = ALUResult[1:0];
                  state_d     = S_REQ;
               end
            end
         end
         S_REQ: begin
            if (busReady) begin
               req_d  = 1'b0;
               addr_d = '0;
               pay_d  = '0;
               if (!pay_q.we) begin
                  rdata_d  = ext_word;
                  rvalid_d = 1'b1;
                end
               state_d = S_DONE;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         state_q   <= S_IDLE;
         req_q     <= 1'b0;
         addr_q    <= '0;
         pay_q     <= '0;
         ld_ctrl_q <= '0;
         off_q     <= '0;
         rdata_q   <= '0;
         rvalid_q  <= 1'b0;
         fault_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         req_q     <= req_d;
         addr_q    <= addr_d;
         pay_q     <= pay_d;
         ld_ctrl_q <= ld_ctrl_d;
         off_q     <= off_d;
         rdata_q   <= rdata_d;
         rvalid_q  <= rvalid_d;
         fault_q   <= fault_d;
      end
   end

   // Stall is combinational so the PC freezes in the same cycle memValid arrives
   assign stall = rstN && (((state_q == S_IDLE) && memValid) || (state_q == S_REQ));

   assign busReq    = req_q;
   assign busWe     = pay_q.we;
   assign busAddr   = addr_q;
   assign busBE     = pay_q.be;
   assign busWData  = pay_q.wdata;
   assign readData  = rdata_q;
   assign readValid = rvalid_q;
   assign fault     = fault_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit with a queue-based expected-result scoreboard.
module tb_load_store_unit;

   logic        clk;
   logic        rstN;
   logic        memValid;
   logic        memWrite;
   logic [2:0]  loadCtrl;
   logic [1:0]  storeCtrl;
   logic [31:0] ALUResult;
   logic [31:0] writeData;
   logic        stall;
   logic [31:0] readData;
   logic        readValid;
   logic        fault;
   logic        busReq;
   logic        busWe;
   logic [31:0] busAddr;
   logic [3:0]  busBE;
   logic [31:0] busWData;
   logic        busReady;
   logic [31:0] busRData;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   typedef struct {
      logic        we;
      logic        fault;
      logic [31:0] addr;
      logic [3:0]  be;
      logic [31:0] wdata;
      logic [31:0] rdata;
   } exp_t;

   typedef struct {
      logic        timeout;
      logic        saw_req;
      logic        stable;
      logic        early;
      int          stall_cycles;
      int          req_k;
      int          req_cyc;
      int          done_cyc;
      logic        we;
      logic [31:0] addr;
      logic [3:0]  be;
      logic [31:0] wdata;
      logic        rvalid;
      logic [31:0] rdata;
      logic        fault;
   } obs_t;

   exp_t sb[$];

   load_store_unit dut (
      .clk       (clk),
      .rstN      (rstN),
      .memValid  (memValid),
      .memWrite  (memWrite),
      .loadCtrl  (loadCtrl),
      .storeCtrl (storeCtrl),
      .ALUResult (ALUResult),
      .writeData (writeData),
      .stall     (stall),
      .readData  (readData),
      .readValid (readValid),
      .fault     (fault),
      .busReq    (busReq),
      .busWe     (busWe),
      .busAddr   (busAddr),
      .busBE     (busBE),
      .busWData  (busWData),
      .busReady  (busReady),
      .busRData  (busRData)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   // Reference behaviour of one access
   function automatic exp_t model(input logic we, input logic [2:0] ld, input logic [1:0] st,
                                  input logic [31:0] addr, input logic [31:0] wd,
                                  input logic [31:0] rword);
      exp_t        e;
      int          size;
      int          off;
      logic [31:0] sh;
      off  = int'(addr[1:0]);
      size = 0;
      if (we) size = (st == 2'b00) ? 1 : (st == 2'b01) ? 2 : (st == 2'b10) ? 4 : 0;
      else if (ld == 3'b000 || ld == 3'b100) size = 1;
      else if (ld == 3'b001 || ld == 3'b101) size = 2;
      else if (ld == 3'b010) size = 4;
      e.we    = we;
      e.fault = (size == 0) || (size == 2 && off % 2 != 0) || (size == 4 && off != 0);
      e.addr  = addr & 32'hFFFF_FFFC;
      e.be    = 4'(((1 << size) - 1) << off);
      e.wdata = 32'd0;
      if (we) e.wdata = (size == 1) ? {4{wd[7:0]}} : (size == 2) ? {2{wd[15:0]}} : wd;
      sh = rword >> (8 * off);
      case (ld)
         3'b000:  e.rdata = 32'($signed(sh[7:0]));
         3'b001:  e.rdata = 32'($signed(sh[15:0]));
         3'b100:  e.rdata = 32'(sh[7:0]);
         3'b101:  e.rdata = 32'(sh[15:0]);
         default: e.rdata = sh;
      endcase
      return e;
   endfunction

   // Presents one instruction, plays the bus with wait_n wait cycles, records what the DUT did
   task automatic run_access(input logic we, input logic [2:0] ld, input logic [1:0] st,
                             input logic [31:0] addr, input logic [31:0] wd,
                             input logic [31:0] rword, input int wait_n, output obs_t o);
      int waited;
      o = '{timeout: 1'b1, stable: 1'b1, default: 0};
      waited = 0;
      @(negedge clk);
      memValid = 1'b1; memWrite = we; loadCtrl = ld; storeCtrl = st;
      ALUResult = addr; writeData = wd; busRData = rword; busReady = 1'b0;
      for (int k = 0; k < 60; k++) begin
         if (k > 0) @(negedge clk);
         #1;
         if (busReq) begin
            if (!o.saw_req) begin
               o.saw_req = 1'b1; o.req_k = k; o.req_cyc = cyc;
               o.we = busWe; o.addr = busAddr; o.be = busBE; o.wdata = busWData;
            end else if ({busWe, busAddr, busBE, busWData} !== {o.we, o.addr, o.be, o.wdata}) begin
               o.stable = 1'b0;
            end
            busReady = (waited == wait_n);
            waited++;
         end else begin
            busReady = 1'b0;
         end
         if (k > 0 && !stall) begin
            o.timeout = 1'b0; o.done_cyc = cyc;
            o.rvalid = readValid; o.rdata = readData; o.fault = fault;
            break;
         end
         if (readValid || fault) o.early = 1'b1;
         if (stall) o.stall_cycles++;
      end
      memValid = 1'b0;
      busReady = 1'b0;
   endtask

   task automatic test_reset;
      rstN = 1'b0; memValid = 1'b1; memWrite = 1'b0; loadCtrl = 3'b010; storeCtrl = 2'b00;
      ALUResult = 32'h40; writeData = 32'h0; busReady = 1'b0; busRData = 32'h0;
      #12;
      checks++;
      if ({busReq, busWe, busAddr, busBE, busWData, readData, readValid, fault} !== 104'd0) begin
         failures++;
         $display("FAIL reset_outputs got req=%b we=%b addr=%h be=%b wd=%h rd=%h rv=%b f=%b exp all zero",
                  busReq, busWe, busAddr, busBE, busWData, readData, readValid, fault);
      end
      checks++;
      if (stall !== 1'b0) begin
         failures++; $display("FAIL reset_stall got=%b exp=0", stall);
      end
      memValid = 1'b0;
      @(negedge clk); rstN = 1'b1;
      @(negedge clk); #1;
      checks++;
      if ({stall, busReq} !== 2'b00) begin
         failures++; $display("FAIL reset_idle got stall=%b req=%b exp 0 0", stall, busReq);
      end
   endtask

   task automatic test_sw;
      obs_t o; exp_t e;
      sb.push_back(model(1'b1, 3'b000, 2'b10, 32'h100, 32'hDEADBEEF, 32'h0));
      run_access(1'b1, 3'b000, 2'b10, 32'h100, 32'hDEADBEEF, 32'h0, 0, o);
      e = sb.pop_front();
      checks++;
      if (o.timeout || !o.saw_req || o.req_k != 1) begin
         failures++; $display("FAIL sw_req got timeout=%b req=%b k=%0d exp req at cycle 1", o.timeout, o.saw_req, o.req_k);
      end
      checks++;
      if ({o.we, o.addr, o.be, o.wdata} !== {e.we, e.addr, e.be, e.wdata}) begin
         failures++; $display("FAIL sw_bus got we=%b a=%h be=%b wd=%h exp we=%b a=%h be=%b wd=%h",
                              o.we, o.addr, o.be, o.wdata, e.we, e.addr, e.be, e.wdata);
      end
      checks++;
      if (o.stall_cycles != 2) begin
         failures++; $display("FAIL sw_stall got=%0d exp=2", o.stall_cycles);
      end
      checks++;
      if ({o.rvalid, o.fault, o.early} !== 3'b000) begin
         failures++; $display("FAIL sw_flags got rv=%b f=%b early=%b exp 0 0 0", o.rvalid, o.fault, o.early);
      end
   endtask

   task automatic test_lb;
      obs_t o; exp_t e;
      for (int i = 0; i < 2; i++) begin
         logic [2:0] ld;
         ld = (i == 0) ? 3'b000 : 3'b100;
         sb.push_back(model(1'b0, ld, 2'b00, 32'h203, 32'h0, 32'h80FF_0000));
         run_access(1'b0, ld, 2'b00, 32'h203, 32'h0, 32'h80FF_0000, 0, o);
         e = sb.pop_front();
         checks++;
         if (o.be !== 4'b1000 || o.addr !== e.addr || o.we !== 1'b0 || o.wdata !== 32'd0) begin
            failures++; $display("FAIL lb_bus[%0d] got be=%b a=%h we=%b wd=%h exp be=1000 a=%h we=0 wd=0",
                                 i, o.be, o.addr, o.we, o.wdata, e.addr);
         end
         checks++;
         if (o.timeout || o.rvalid !== 1'b1 || o.rdata !== e.rdata || o.fault !== 1'b0) begin
            failures++; $display("FAIL lb_data[%0d] got rv=%b rd=%h f=%b exp rv=1 rd=%h f=0",
                                 i, o.rvalid, o.rdata, o.fault, e.rdata);
         end
      end
   endtask

   task automatic test_lh_wait;
      obs_t o; exp_t e;
      sb.push_back(model(1'b0, 3'b001, 2'b00, 32'h102, 32'h0, 32'h8001_1234));
      run_access(1'b0, 3'b001, 2'b00, 32'h102, 32'h0, 32'h8001_1234, 3, o);
      e = sb.pop_front();
      checks++;
      if (o.timeout || o.rvalid !== 1'b1 || o.rdata !== e.rdata) begin
         failures++; $display("FAIL lh_data got rv=%b rd=%h exp rv=1 rd=%h", o.rvalid, o.rdata, e.rdata);
      end
      checks++;
      if (o.stall_cycles != 5) begin
         failures++; $display("FAIL lh_stall got=%0d exp=5", o.stall_cycles);
      end
      checks++;
      if (!o.stable || o.be !== e.be || o.addr !== e.addr) begin
         failures++; $display("FAIL lh_bus got stable=%b be=%b a=%h exp stable=1 be=%b a=%h",
                              o.stable, o.be, o.addr, e.be, e.addr);
      end
   endtask

   task automatic test_fault;
      obs_t o; exp_t e;
      for (int i = 0; i < 2; i++) begin
         logic we;
         logic [31:0] a;
         we = (i == 0);
         a  = (i == 0) ? 32'h101 : 32'h100;
         sb.push_back(model(we, 3'b011, 2'b01, a, 32'h5555, 32'h0));
         run_access(we, 3'b011, 2'b01, a, 32'h5555, 32'h0, 0, o);
         e = sb.pop_front();
         checks++;
         if (o.timeout || o.fault !== e.fault || o.rvalid !== 1'b0 || o.early) begin
            failures++; $display("FAIL fault_pulse[%0d] got f=%b rv=%b early=%b exp f=%b rv=0", i, o.fault, o.rvalid, o.early, e.fault);
         end
         checks++;
         if (o.saw_req || o.stall_cycles != 1) begin
            failures++; $display("FAIL fault_nobus[%0d] got req=%b stall=%0d exp req=0 stall=1", i, o.saw_req, o.stall_cycles);
         end
      end
   endtask

   task automatic test_reset_mid_access;
      @(negedge clk);
      memValid = 1'b1; memWrite = 1'b0; loadCtrl = 3'b010; ALUResult = 32'h40; busReady = 1'b0;
      @(negedge clk); @(negedge clk); #1;
      checks++;
      if (busReq !== 1'b1) begin
         failures++; $display("FAIL rst_mid_pre got req=%b exp=1", busReq);
      end
      #2 rstN = 1'b0;
      #1;
      checks++;
      if ({busReq, stall, readValid} !== 3'b000) begin
         failures++; $display("FAIL rst_mid_async got req=%b stall=%b rv=%b exp 0 0 0", busReq, stall, readValid);
      end
      memValid = 1'b0;
      @(negedge clk); rstN = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk); #1;
         checks++;
         if ({busReq, stall, readValid, fault} !== 4'b0000) begin
            failures++; $display("FAIL rst_mid_idle[%0d] got req=%b stall=%b rv=%b f=%b exp 0 0 0 0",
                                 i, busReq, stall, readValid, fault);
         end
      end
   endtask

   task automatic test_back_to_back;
      obs_t o1, o2; exp_t e1, e2;
      sb.push_back(model(1'b1, 3'b000, 2'b00, 32'h0, 32'h1234_56A5, 32'h0));
      sb.push_back(model(1'b0, 3'b010, 2'b00, 32'h4, 32'h0, 32'hCAFE_F00D));
      run_access(1'b1, 3'b000, 2'b00, 32'h0, 32'h1234_56A5, 32'h0, 0, o1);
      run_access(1'b0, 3'b010, 2'b00, 32'h4, 32'h0, 32'hCAFE_F00D, 0, o2);
      e1 = sb.pop_front();
      e2 = sb.pop_front();
      checks++;
      if (o1.wdata !== e1.wdata || o1.be !== 4'b0001 || o1.we !== 1'b1) begin
         failures++; $display("FAIL b2b_sb got wd=%h be=%b we=%b exp wd=%h be=0001 we=1", o1.wdata, o1.be, o1.we, e1.wdata);
      end
      checks++;
      if (o2.timeout || o2.rdata !== e2.rdata || o2.addr !== e2.addr || o2.be !== e2.be) begin
         failures++; $display("FAIL b2b_lw got rd=%h a=%h be=%b exp rd=%h a=%h be=%b", o2.rdata, o2.addr, o2.be, e2.rdata, e2.addr, e2.be);
      end
      checks++;
      if (o2.req_cyc - o1.done_cyc != 2) begin
         failures++; $display("FAIL b2b_gap got=%0d exp=2", o2.req_cyc - o1.done_cyc);
      end
   endtask

   task automatic test_random;
      obs_t o; exp_t e;
      for (int i = 0; i < 40; i++) begin
         logic we; logic [2:0] ld; logic [1:0] st; logic [31:0] a, wd, rw; int w;
         we = 1'($urandom_range(0, 1)); ld = 3'($urandom_range(0, 7)); st = 2'($urandom_range(0, 3));
         a = $urandom; wd = $urandom; rw = $urandom; w = $urandom_range(0, 2);
         sb.push_back(model(we, ld, st, a, wd, rw));
         run_access(we, ld, st, a, wd, rw, w, o);
         e = sb.pop_front();
         checks++;
         if (o.timeout || o.fault !== e.fault || o.saw_req !== !e.fault || o.early) begin
            failures++; $display("FAIL rand_flow[%0d] got to=%b f=%b req=%b early=%b exp f=%b req=%b",
                                 i, o.timeout, o.fault, o.saw_req, o.early, e.fault, !e.fault);
         end else if (!e.fault) begin
            checks++;
            if ({o.we, o.addr, o.be, o.wdata} !== {e.we, e.addr, e.be, e.wdata} || !o.stable) begin
               failures++; $display("FAIL rand_bus[%0d] got we=%b a=%h be=%b wd=%h st=%b exp we=%b a=%h be=%b wd=%h",
                                    i, o.we, o.addr, o.be, o.wdata, o.stable, e.we, e.addr, e.be, e.wdata);
            end
            checks++;
            if (o.rvalid !== !e.we || (!e.we && o.rdata !== e.rdata) || o.stall_cycles != 2 + w) begin
               failures++; $display("FAIL rand_done[%0d] got rv=%b rd=%h stall=%0d exp rv=%b rd=%h stall=%0d",
                                    i, o.rvalid, o.rdata, o.stall_cycles, !e.we, e.rdata, 2 + w);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_sw();
      test_lb();
      test_lh_wait();
      test_fault();
      test_reset_mid_access();
      test_back_to_back();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
